// File: rtl/mul_float_pipe.sv
// Three-stage IEEE-754 style multiplier: unpack/special, multiply, round/pack.
// Flush-to-zero on inputs and underflow; REQ/BUSY handshake on both sides.
module mul_float_pipe #(
  parameter int P_EXP = 8,
  parameter int P_MAN = 23,
  parameter int P_TAG = 4
) (
  input  logic                     iCLOCK,
  input  logic                     inRESET,
  input  logic                     iRESET_SYNC,
  input  logic                     iDATA_REQ,
  output logic                     oDATA_BUSY,
  input  logic [P_EXP+P_MAN:0]     iDATA_A,
  input  logic [P_EXP+P_MAN:0]     iDATA_B,
  input  logic [1:0]               iRMODE,
  input  logic [P_TAG-1:0]         iTAG,
  output logic                     oDATA_VALID,
  input  logic                     iDATA_BUSY,
  output logic [P_EXP+P_MAN:0]     oDATA,
  output logic [3:0]               oFLAGS,
  output logic [P_TAG-1:0]         oTAG
);

  localparam int W  = 1 + P_EXP + P_MAN;
  localparam int EW = P_EXP + 2;
  localparam int PW = 2 * P_MAN + 2;
  localparam int MW = P_MAN + 1;

  localparam logic [EW-1:0] BIAS  = EW'((1 << (P_EXP - 1)) - 1);
  localparam logic [EW-1:0] EMAXE = EW'((1 << P_EXP) - 1);
  localparam logic [P_EXP-1:0] EONE = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, {P_EXP{1'b1}}, 1'b1, {(P_MAN-1){1'b0}}};
  localparam logic [W-2:0] INFM = {{P_EXP{1'b1}}, {P_MAN{1'b0}}};
  localparam logic [W-2:0] MAXM =
    {{(P_EXP-1){1'b1}}, 1'b0, {P_MAN{1'b1}}};

  logic stall, acc;

  logic             v1_q, v2_q, v3_q;
  logic             sg1_q, sg2_q;
  logic [EW-1:0]    e1_q, e2_q;
  logic [MW-1:0]    ma1_q, mb1_q;
  logic [PW-1:0]    prod2_q;
  logic             sp1_q, sp2_q;
  logic [W-1:0]     spv1_q, spv2_q;
  logic [3:0]       spf1_q, spf2_q;
  logic [1:0]       rm1_q, rm2_q;
  logic [P_TAG-1:0] tag1_q, tag2_q, tag_q;
  logic [W-1:0]     data_q;
  logic [3:0]       flg_q;

  assign stall       = v3_q && iDATA_BUSY;
  assign acc         = iDATA_REQ && !stall;
  assign oDATA_BUSY  = stall;
  assign oDATA_VALID = v3_q;
  assign oDATA       = data_q;
  assign oFLAGS      = flg_q;
  assign oTAG        = tag_q;

  // S1: unpack and classify
  logic             sa, sb, sg_d;
  logic [P_EXP-1:0] ea, eb;
  logic [P_MAN-1:0] ma, mb;
  logic             za, zb, ia, ib, na, nb, sna, snb;
  logic             sp_d;
  logic [W-1:0]     spv_d;
  logic [3:0]       spf_d;
  logic [EW-1:0]    e_d;

  assign {sa, ea, ma} = iDATA_A;
  assign {sb, eb, mb} = iDATA_B;
  assign sg_d = sa ^ sb;
  assign za   = (ea == '0);
  assign zb   = (eb == '0);
  assign ia   = (ea == EONE) && (ma == '0);
  assign ib   = (eb == EONE) && (mb == '0);
  assign na   = (ea == EONE) && (ma != '0);
  assign nb   = (eb == EONE) && (mb != '0);
  assign sna  = na && !ma[P_MAN-1];
  assign snb  = nb && !mb[P_MAN-1];
  assign e_d  = {2'b00, ea} + {2'b00, eb} - BIAS;

  always_comb begin
    sp_d  = 1'b1;
    spv_d = QNAN;
    spf_d = 4'b0000;
    if (na || nb) begin
      spf_d = (sna || snb) ? 4'b1000 : 4'b0000;
    end else if ((ia && zb) || (ib && za)) begin
      spf_d = 4'b1000;
    end else if (ia || ib) begin
      spv_d = {sg_d, INFM};
    end else if (za || zb) begin
      spv_d = {sg_d, {(W-1){1'b0}}};
    end else begin
      sp_d = 1'b0;
    end
  end

  // S2: mantissa product
  logic [PW-1:0] prod_d;
  assign prod_d = {{MW{1'b0}}, ma1_q} * {{MW{1'b0}}, mb1_q};

  // S3: normalise, round, pack
  logic [PW-2:0]    n;
  logic [EW-1:0]    e_n, e_r;
  logic [P_MAN-1:0] kept, man_f;
  logic             g, st, inc, carry, ovf, unf;
  logic [MW-1:0]    mant_r;
  logic [W-1:0]     res_d;
  logic [3:0]       flg_d;

  assign n      = prod2_q[PW-1] ? prod2_q[PW-2:0]
                                : {prod2_q[PW-3:0], 1'b0};
  assign e_n    = e2_q + {{(EW-1){1'b0}}, prod2_q[PW-1]};
  assign kept   = n[PW-2:MW];
  assign g      = n[P_MAN];
  assign st     = |n[P_MAN-1:0];
  assign mant_r = {1'b0, kept} + {{P_MAN{1'b0}}, inc};
  assign carry  = mant_r[P_MAN];
  assign man_f  = carry ? '0 : mant_r[P_MAN-1:0];
  assign e_r    = e_n + {{(EW-1){1'b0}}, carry};
  assign ovf    = $signed(e_r) >= $signed(EMAXE);
  assign unf    = e_r[EW-1] || (e_r == '0);

  always_comb begin
    inc = 1'b0;
    unique case (rm2_q)
      2'b00:   inc = g && (st || kept[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = (g || st) && !sg2_q;
      default: inc = (g || st) && sg2_q;
    endcase
  end

  always_comb begin
    res_d = {sg2_q, e_r[P_EXP-1:0], man_f};
    flg_d = {3'b000, g || st};
    if (sp2_q) begin
      res_d = spv2_q;
      flg_d = spf2_q;
    end else if (ovf) begin
      flg_d = 4'b0101;
      unique case (rm2_q)
        2'b00:   res_d = {sg2_q, INFM};
        2'b01:   res_d = {sg2_q, MAXM};
        2'b10:   res_d = {sg2_q, sg2_q ? MAXM : INFM};
        default: res_d = {sg2_q, sg2_q ? INFM : MAXM};
      endcase
    end else if (unf) begin
      res_d = {sg2_q, {(W-1){1'b0}}};
      flg_d = 4'b0011;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      sg1_q   <= 1'b0;
      sg2_q   <= 1'b0;
      e1_q    <= '0;
      e2_q    <= '0;
      ma1_q   <= '0;
      mb1_q   <= '0;
      prod2_q <= '0;
      sp1_q   <= 1'b0;
      sp2_q   <= 1'b0;
      spv1_q  <= '0;
      spv2_q  <= '0;
      spf1_q  <= '0;
      spf2_q  <= '0;
      rm1_q   <= '0;
      rm2_q   <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      flg_q   <= '0;
    end else if (iRESET_SYNC) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
      flg_q  <= '0;
    end else if (!stall) begin
      v1_q <= acc;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (acc) begin
        sg1_q  <= sg_d;
        e1_q   <= e_d;
        ma1_q  <= {1'b1, ma};
        mb1_q  <= {1'b1, mb};
        sp1_q  <= sp_d;
        spv1_q <= spv_d;
        spf1_q <= spf_d;
        rm1_q  <= iRMODE;
        tag1_q <= iTAG;
      end
      if (v1_q) begin
        sg2_q   <= sg1_q;
        e2_q    <= e1_q;
        prod2_q <= prod_d;
        sp2_q   <= sp1_q;
        spv2_q  <= spv1_q;
        spf2_q  <= spf1_q;
        rm2_q   <= rm1_q;
        tag2_q  <= tag1_q;
      end
      if (v2_q) begin
        data_q <= res_d;
        flg_q  <= flg_d;
        tag_q  <= tag2_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_float_pipe.sv
// Directed bench for mul_float_pipe: single and half precision instances,
// rounding, specials, stall ordering, async and sync reset flush.
module tb_mul_float_pipe;

  logic clk = 1'b0;
  logic rst_n, srst;

  logic        f_req, f_obusy, f_val, f_busy;
  logic [31:0] f_a, f_b, f_data;
  logic [1:0]  f_rm;
  logic [3:0]  f_tag, f_flg, f_otag;

  logic        h_req, h_obusy, h_val;
  logic [15:0] h_a, h_b, h_data;
  logic [1:0]  h_rm;
  logic [3:0]  h_tag, h_flg, h_otag;

  int n_chk = 0;
  int n_pass = 0;

  mul_float_pipe u_f (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(srst),
    .iDATA_REQ(f_req), .oDATA_BUSY(f_obusy),
    .iDATA_A(f_a), .iDATA_B(f_b), .iRMODE(f_rm), .iTAG(f_tag),
    .oDATA_VALID(f_val), .iDATA_BUSY(f_busy),
    .oDATA(f_data), .oFLAGS(f_flg), .oTAG(f_otag)
  );

  mul_float_pipe #(.P_EXP(5), .P_MAN(10), .P_TAG(4)) u_h (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(srst),
    .iDATA_REQ(h_req), .oDATA_BUSY(h_obusy),
    .iDATA_A(h_a), .iDATA_B(h_b), .iRMODE(h_rm), .iTAG(h_tag),
    .oDATA_VALID(h_val), .iDATA_BUSY(1'b0),
    .oDATA(h_data), .oFLAGS(h_flg), .oTAG(h_otag)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h want %h", nm, got, exp);
  endtask

  task automatic run(input bit h, input logic [31:0] a, b,
                     input logic [1:0] rm, input logic [3:0] tg,
                     input logic [31:0] ed, input logic [3:0] ef,
                     input string nm);
    int lat;
    if (h) begin
      h_a = a[15:0]; h_b = b[15:0]; h_rm = rm; h_tag = tg; h_req = 1'b1;
    end else begin
      f_a = a; f_b = b; f_rm = rm; f_tag = tg; f_req = 1'b1;
    end
    @(posedge clk); #1;
    f_req = 1'b0; h_req = 1'b0;
    lat = 1;
    while (!(h ? h_val : f_val) && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, ".lat"}, 32'(lat), 32'd3);
    chk({nm, ".data"}, h ? {16'h0, h_data} : f_data, ed);
    chk({nm, ".flags"}, {28'h0, h ? h_flg : f_flg}, {28'h0, ef});
    chk({nm, ".tag"}, {28'h0, h ? h_otag : f_otag}, {28'h0, tg});
  endtask

  task automatic no_valid(input string nm);
    int cnt;
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (f_val) cnt++;
    end
    chk(nm, 32'(cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; srst = 1'b0;
    f_req = 0; f_a = 0; f_b = 0; f_rm = 0; f_tag = 0; f_busy = 0;
    h_req = 0; h_a = 0; h_b = 0; h_rm = 0; h_tag = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'h0, f_val}, 32'd0);
    chk("rst.data", f_data, 32'h0);
    chk("rst.flags", {28'h0, f_flg}, 32'h0);
    chk("rst.busy", {31'h0, f_obusy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, 32'h41200000, 32'h41200000, 2'b00, 4'd1, 32'h42C80000, 4'b0000, "ten");
    run(0, 32'h447A0000, 32'h447A0000, 2'b00, 4'd2, 32'h49742400, 4'b0000, "thou");
    run(0, 32'h3F800001, 32'h3F800001, 2'b00, 4'd3, 32'h3F800002, 4'b0001, "ulp.rne");
    run(0, 32'h3F800001, 32'h3F800001, 2'b01, 4'd4, 32'h3F800002, 4'b0001, "ulp.rtz");
    run(0, 32'h3F800001, 32'h3F800001, 2'b10, 4'd5, 32'h3F800003, 4'b0001, "ulp.rup");
    run(0, 32'h3FFFFFFF, 32'h3FFFFFFF, 2'b00, 4'd6, 32'h407FFFFE, 4'b0001, "nrm.rne");
    run(0, 32'h3FFFFFFF, 32'h3FFFFFFF, 2'b10, 4'd7, 32'h407FFFFF, 4'b0001, "nrm.rup");
    run(0, 32'h7F000000, 32'h7F000000, 2'b00, 4'd8, 32'h7F800000, 4'b0101, "ovf.rne");
    run(0, 32'h7F000000, 32'h7F000000, 2'b01, 4'd9, 32'h7F7FFFFF, 4'b0101, "ovf.rtz");
    run(0, 32'hFF000000, 32'h7F000000, 2'b11, 4'd10, 32'hFF800000, 4'b0101, "ovf.rdn");
    run(0, 32'hFF000000, 32'h7F000000, 2'b10, 4'd11, 32'hFF7FFFFF, 4'b0101, "ovf.rup");
    run(0, 32'h7F800000, 32'h00000000, 2'b00, 4'd12, 32'h7FC00000, 4'b1000, "inf0");
    run(0, 32'h7F800001, 32'h3F800000, 2'b00, 4'd13, 32'h7FC00000, 4'b1000, "snan");
    run(0, 32'h7FC00000, 32'h3F800000, 2'b00, 4'd14, 32'h7FC00000, 4'b0000, "qnan");
    run(0, 32'h7F800000, 32'hC0000000, 2'b00, 4'd15, 32'hFF800000, 4'b0000, "infx");
    run(0, 32'h80000000, 32'h3F800000, 2'b00, 4'd1, 32'h80000000, 4'b0000, "negz");
    run(0, 32'h00000001, 32'h3F800000, 2'b00, 4'd2, 32'h00000000, 4'b0000, "ftz");
    run(0, 32'h00800000, 32'h00800000, 2'b00, 4'd3, 32'h00000000, 4'b0011, "unf");
    run(1, 32'h4900, 32'h4900, 2'b00, 4'd4, 32'h5640, 4'b0000, "h.ten");
    run(1, 32'h7BFF, 32'h7BFF, 2'b01, 4'd5, 32'h7BFF, 4'b0101, "h.ovf");

    f_busy = 1'b1; f_rm = 2'b00; f_req = 1'b1;
    f_a = 32'h41200000; f_b = 32'h41200000; f_tag = 4'd1;
    @(posedge clk); #1;
    f_a = 32'h447A0000; f_b = 32'h447A0000; f_tag = 4'd2;
    @(posedge clk); #1;
    f_a = 32'h3F800000; f_b = 32'h40000000; f_tag = 4'd3;
    @(posedge clk); #1;
    f_a = 32'h3F800000; f_b = 32'h3F800000; f_tag = 4'd4;
    chk("stall.valid", {31'h0, f_val}, 32'd1);
    chk("stall.busy", {31'h0, f_obusy}, 32'd1);
    chk("stall.tag", {28'h0, f_otag}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    f_req = 1'b0;
    chk("hold.data", f_data, 32'h42C80000);
    chk("hold.tag", {28'h0, f_otag}, 32'd1);
    f_busy = 1'b0;
    @(posedge clk); #1;
    chk("drain2.data", f_data, 32'h49742400);
    chk("drain2.tag", {28'h0, f_otag}, 32'd2);
    @(posedge clk); #1;
    chk("drain3.data", f_data, 32'h40000000);
    chk("drain3.tag", {28'h0, f_otag}, 32'd3);
    @(posedge clk); #1;
    chk("drain.end", {31'h0, f_val}, 32'd0);

    f_req = 1'b1; f_a = 32'h40000000; f_b = 32'h40000000; f_tag = 4'd5;
    @(posedge clk); #1;
    f_tag = 4'd6;
    @(posedge clk); #1;
    f_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'h0, f_val}, 32'd0);
    chk("arst.data", f_data, 32'h0);
    chk("arst.tag", {28'h0, f_otag}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    no_valid("arst.late");

    run(0, 32'h40400000, 32'h40000000, 2'b00, 4'd7, 32'h40C00000, 4'b0000, "three");
    f_req = 1'b1; f_a = 32'h40000000; f_b = 32'h40000000; f_tag = 4'd8;
    @(posedge clk); #1;
    f_tag = 4'd9;
    @(posedge clk); #1;
    f_req = 1'b0; srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    chk("srst.valid", {31'h0, f_val}, 32'd0);
    chk("srst.data", f_data, 32'h0);
    chk("srst.tag", {28'h0, f_otag}, 32'h0);
    no_valid("srst.late");

    run(0, 32'h41200000, 32'h41200000, 2'b00, 4'd10, 32'h42C80000, 4'b0000, "post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
